// File: rtl/vga_timing_pkg.sv
// Shared timing constants and state type for the 640x480@72Hz raster generator.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      SETTLE,
      RUN
   } lock_state_t;

   // VESA 640x480@72Hz defaults (31.5 MHz pixel clock)
   localparam int H_ACTIVE_DEF  = 640;
   localparam int H_FP_DEF      = 24;
   localparam int H_SYNC_DEF    = 40;
   localparam int H_BP_DEF      = 128;
   localparam int V_ACTIVE_DEF  = 480;
   localparam int V_FP_DEF      = 9;
   localparam int V_SYNC_DEF    = 3;
   localparam int V_BP_DEF      = 28;
   localparam int SYNC_NEG_DEF  = 1;
   localparam int LOCK_WAIT_DEF = 1024;

   // Width of the pixel coordinate buses; holds 0..831 and 0..519
   localparam int PIX_W = 10;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus its active/sync window decode.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF,
   parameter int WIDTH  = PIX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             active,
   output logic             sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
   localparam logic [WIDTH-1:0] ACTIVE_END = WIDTH'(ACTIVE);
   localparam logic [WIDTH-1:0] SYNC_BEG   = WIDTH'(ACTIVE + FP);
   localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FP + SYNC);

   // Position advances when enabled and wraps to zero after the last position
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

   assign tc     = (count == LAST);
   assign active = (count < ACTIVE_END);
   assign sync   = (count >= SYNC_BEG) && (count < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Lock-qualified 640x480@72Hz raster timing generator with registered outputs.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE  = H_ACTIVE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_ACTIVE  = V_ACTIVE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF,
   parameter int SYNC_NEG  = SYNC_NEG_DEF,
   parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             locked,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [PIX_W-1:0] pix_x,
   output logic [PIX_W-1:0] pix_y,
   output logic             frame_start,
   output logic             running
);

   localparam int              LOCK_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WAIT - 1);
   localparam logic            SYNC_IDLE = (SYNC_NEG != 0);

   lock_state_t       state;
   lock_state_t       state_next;
   logic [LOCK_W-1:0] lock_cnt;
   logic [LOCK_W-1:0] lock_cnt_next;

   logic             raster_en;
   logic             raster_clr;
   logic             at_origin;
   logic [PIX_W-1:0] h_cnt;
   logic [PIX_W-1:0] v_cnt;
   logic             h_tc;
   logic             v_tc;
   logic             h_active;
   logic             v_active;
   logic             h_sync;
   logic             v_sync;

   // Lock qualification state and consecutive-locked counter
   always_ff @(posedge refclk) begin
      if (rst) begin
         state    <= WAIT_LOCK;
         lock_cnt <= '0;
      end else begin
         state    <= state_next;
         lock_cnt <= lock_cnt_next;
      end
   end

   // Any low cycle of locked sends the FSM back to waiting, even on the final settle cycle
   always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      case (state)
         WAIT_LOCK: begin
            lock_cnt_next = '0;
            if (locked) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (!locked) begin
               state_next    = WAIT_LOCK;
               lock_cnt_next = '0;
            end else if (lock_cnt == LOCK_LAST) begin
               state_next    = RUN;
               lock_cnt_next = '0;
            end else begin
               lock_cnt_next = lock_cnt + 1'b1;
            end
         end
         RUN: begin
            if (!locked) begin
               state_next = WAIT_LOCK;
            end
         end
         default: begin
            state_next    = WAIT_LOCK;
            lock_cnt_next = '0;
         end
      endcase
   end

   // Counters sit at 0,0 outside RUN so the first RUN cycle starts a fresh frame
   assign raster_en  = (state == RUN) && locked;
   assign raster_clr = (state != RUN);

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .WIDTH  (PIX_W)
   ) u_h_axis (
      .clk    (refclk),
      .rst    (rst),
      .en     (raster_en),
      .clr    (raster_clr),
      .count  (h_cnt),
      .tc     (h_tc),
      .active (h_active),
      .sync   (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .WIDTH  (PIX_W)
   ) u_v_axis (
      .clk    (refclk),
      .rst    (rst),
      .en     (raster_en && h_tc),
      .clr    (raster_clr),
      .count  (v_cnt),
      .tc     (v_tc),
      .active (v_active),
      .sync   (v_sync)
   );

   // Tracks whether the counters are at 0,0: set by a clear or by a full-frame wrap
   always_ff @(posedge refclk) begin
      if (rst || raster_clr) begin
         at_origin <= 1'b1;
      end else if (raster_en) begin
         at_origin <= h_tc && v_tc;
      end
   end

   // Output register: describes the previous cycle's counters, forced idle the moment lock drops
   always_ff @(posedge refclk) begin
      if (rst || (state != RUN) || !locked) begin
         hsync       <= SYNC_IDLE;
         vsync       <= SYNC_IDLE;
         de          <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         hsync       <= h_sync ^ SYNC_IDLE;
         vsync       <= v_sync ^ SYNC_IDLE;
         de          <= h_active && v_active;
         pix_x       <= h_cnt;
         pix_y       <= v_cnt;
         frame_start <= at_origin;
         running     <= 1'b1;
      end
   end

endmodule
